// File: rtl/mtr_pwm_drv.sv
// mtr_pwm_drv: signed 12-bit speed command -> fixed-period PWM, direction bit and a
// dead-timed complementary gate pair. Overcurrent shutdown is built only with OVR_I_SHTDWN_EN.
module mtr_pwm_drv #(
  parameter int DEADTIME  = 32,
  parameter int BLANK     = 128,
  parameter int OVR_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] duty,
  input  logic        ovr_I,
  output logic        pwm_synch,
  output logic        pwm_h,
  output logic        pwm_l,
  output logic        dir,
  output logic        fault
);

  localparam logic [7:0] DT_MAX = 8'(DEADTIME);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;
  state_t state, state_next;

  logic [10:0] cnt;
  logic [10:0] mag_q;
  logic [11:0] duty_abs;
  logic [10:0] duty_mag;
  logic        cnt_zero;
  logic        cnt_last;
  logic        raw;
  logic        raw_q;
  logic [7:0]  dt_cnt;
  logic [7:0]  dt_cur;
  logic        dt_done;
  logic        ovr_trip;

  assign cnt_zero = (cnt == 11'd0);
  assign cnt_last = (cnt == 11'd2047);
  assign duty_abs = duty[11] ? (~duty + 12'd1) : duty;
  // Only -2048 still has bit 11 set after negation; clamp it to full scale.
  assign duty_mag = duty_abs[11] ? 11'h7FF : duty_abs[10:0];
  assign raw      = (cnt < mag_q);
  assign dt_cur   = (raw != raw_q) ? 8'd0 :
                    ((dt_cnt == DT_MAX) ? DT_MAX : dt_cnt + 8'd1);
  assign dt_done  = (dt_cur == DT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 11'd0;
      mag_q  <= 11'd0;
      dir    <= 1'b0;
      raw_q  <= 1'b0;
      dt_cnt <= 8'd0;
    end else begin
      cnt    <= cnt + 11'd1;
      raw_q  <= raw;
      dt_cnt <= dt_cur;
      if (cnt_zero) begin
        mag_q <= duty_mag;
        dir   <= duty[11];
      end
    end
  end

`ifdef OVR_I_SHTDWN_EN
  localparam logic [10:0] BLANK_C = 11'(BLANK);
  localparam logic [3:0]  LIMIT_C = 4'(OVR_LIMIT);

  logic       ovr_flag;
  logic       ovr_hit;
  logic [3:0] ovr_cnt;

  assign ovr_hit = ovr_I & pwm_h & (cnt >= BLANK_C);

  // Per-period overcurrent flag feeds a run of consecutive bad periods.
  always_ff @(posedge clk) begin
    if (rst || (state != RUN)) begin
      ovr_flag <= 1'b0;
      ovr_cnt  <= 4'd0;
    end else begin
      if (cnt_zero)
        ovr_flag <= 1'b0;
      else if (ovr_hit)
        ovr_flag <= 1'b1;
      if (cnt_last)
        ovr_cnt <= (ovr_flag || ovr_hit) ? ovr_cnt + 4'd1 : 4'd0;
    end
  end

  assign ovr_trip = (ovr_cnt >= LIMIT_C);
`else
  logic unused_ovr;
  // ovr_I and the shutdown parameters have no function in this build.
  assign unused_ovr = ^{ovr_I, 11'(BLANK), 4'(OVR_LIMIT)};
  assign ovr_trip   = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en && cnt_zero) state_next = RUN;
      RUN:     if (!en) state_next = IDLE;
               else if (ovr_trip) state_next = FAULT;
      FAULT:   if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs follow the next state so gates drop in the cycle after en falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pwm_synch <= 1'b0;
      pwm_h     <= 1'b0;
      pwm_l     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_next;
      pwm_synch <= cnt_zero;
      pwm_h     <= (state_next == RUN) & raw & dt_done;
      pwm_l     <= (state_next == RUN) & ~raw & dt_done;
      fault     <= (state_next == FAULT);
    end
  end

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// tb_mtr_pwm_drv: scoreboard bench; expected per-period gate widths, dir and fault are
// queued by the stimulus and checked by a monitor that closes each window on pwm_synch.
module tb_mtr_pwm_drv;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] duty;
  logic        ovr_I;
  logic        pwm_synch;
  logic        pwm_h;
  logic        pwm_l;
  logic        dir;
  logic        fault;

`ifdef OVR_I_SHTDWN_EN
  localparam bit SHTDN = 1'b1;
`else
  localparam bit SHTDN = 1'b0;
`endif

  typedef struct {
    int win;
    int h;
    int l;
    bit d;
    bit f;
  } exp_t;

  exp_t sb[$];
  int   errors     = 0;
  int   checks     = 0;
  int   stim_synch = 0;

  mtr_pwm_drv dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .duty      (duty),
    .ovr_I     (ovr_I),
    .pwm_synch (pwm_synch),
    .pwm_h     (pwm_h),
    .pwm_l     (pwm_l),
    .dir       (dir),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [11:0] d);
    en   = e;
    duty = d;
  endtask

  task automatic pushExp(input int h, input int l, input bit d, input bit f);
    exp_t e;
    e.win = stim_synch;
    e.h   = h;
    e.l   = l;
    e.d   = d;
    e.f   = f;
    sb.push_back(e);
  endtask

  task automatic finishRun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Bounded wait for the next period-start pulse.
  task automatic waitSynch(output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      waited++;
      if (pwm_synch === 1'b1) break;
      if (waited >= 3000) begin
        checks++;
        errors++;
        $display("[TB] FAIL synch_timeout: got no pwm_synch in %0d cycles, expected one per 2048", waited);
        finishRun();
      end
    end
    stim_synch++;
  endtask

  // Monitor: accumulate gate activity over cnt==1 .. next cnt==0 and compare on pwm_synch.
  initial begin
    int   mon_synch;
    int   h_acc;
    int   l_acc;
    int   ov_acc;
    bit   f_any;
    bit   w_dir;
    exp_t e;
    mon_synch = 0;
    h_acc = 0; l_acc = 0; ov_acc = 0; f_any = 0; w_dir = 0;
    forever begin
      @(negedge clk);
      if (pwm_synch === 1'b1) begin
        if (mon_synch > 0) begin
          while (sb.size() > 0 && sb[0].win < mon_synch) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL window_missed w%0d: got no closing pwm_synch, expected one", e.win);
          end
          if (sb.size() > 0 && sb[0].win == mon_synch) begin
            e = sb.pop_front();
            checkOutput($sformatf("h_width w%0d", e.win), h_acc, e.h);
            checkOutput($sformatf("l_width w%0d", e.win), l_acc, e.l);
            checkOutput($sformatf("dir w%0d", e.win), {31'd0, w_dir}, {31'd0, e.d});
            checkOutput($sformatf("fault w%0d", e.win), {31'd0, f_any}, {31'd0, e.f});
            checkOutput($sformatf("overlap w%0d", e.win), ov_acc, 0);
          end
        end
        mon_synch++;
        h_acc = 0; l_acc = 0; ov_acc = 0; f_any = 0;
        w_dir = dir;
      end
      if (pwm_h === 1'b1) h_acc++;
      if (pwm_l === 1'b1) l_acc++;
      if (pwm_h === 1'b1 && pwm_l === 1'b1) ov_acc++;
      if (fault === 1'b1) f_any = 1'b1;
    end
  end

  initial begin
    int w;
    rst = 1'b1; ovr_I = 1'b0;
    applyStimulus(1'b0, 12'h000);
    repeat (2) @(negedge clk);
    checkOutput("rst_synch", {31'd0, pwm_synch}, 0);
    checkOutput("rst_pwm_h", {31'd0, pwm_h}, 0);
    checkOutput("rst_pwm_l", {31'd0, pwm_l}, 0);
    checkOutput("rst_dir", {31'd0, dir}, 0);
    checkOutput("rst_fault", {31'd0, fault}, 0);

    // +512: aligned start, then 480/1504 per period
    applyStimulus(1'b1, 12'h200);
    rst = 1'b0;
    waitSynch(w);
    checkOutput("first_synch_latency", w, 1);
    waitSynch(w); pushExp(480, 1504, 1'b0, 1'b0);
    waitSynch(w); pushExp(480, 1504, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    applyStimulus(1'b1, 12'hE00);

    // -512: same widths, reverse direction from the next period
    waitSynch(w); pushExp(480, 1504, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    applyStimulus(1'b1, 12'h800);

    // -2048 saturates to 2047: low-side pulse swallowed
    waitSynch(w); pushExp(2015, 0, 1'b1, 1'b0);
    waitSynch(w); pushExp(2015, 0, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    applyStimulus(1'b1, 12'h000);

    // zero command: low side on continuously
    waitSynch(w);
    waitSynch(w); pushExp(0, 2048, 1'b0, 1'b0);
    waitSynch(w); pushExp(0, 2048, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    applyStimulus(1'b1, 12'h400);
    waitSynch(w);

    // overcurrent inside the blanking window is ignored
    for (int i = 0; i < 3; i++) begin
      waitSynch(w); pushExp(992, 992, 1'b0, 1'b0);
      repeat (99) @(negedge clk);
      ovr_I = 1'b1;
      @(negedge clk);
      ovr_I = 1'b0;
    end

    // overcurrent after blanking for three consecutive periods
    for (int i = 0; i < 3; i++) begin
      waitSynch(w); pushExp(992, 992, 1'b0, 1'b0);
      repeat (599) @(negedge clk);
      ovr_I = 1'b1;
      @(negedge clk);
      ovr_I = 1'b0;
    end
    waitSynch(w); pushExp(SHTDN ? 0 : 992, SHTDN ? 0 : 992, 1'b0, SHTDN);

    // en pulse low clears the fault; RUN resumes at the next period
    waitSynch(w); pushExp(0, 0, 1'b0, SHTDN);
    repeat (10) @(negedge clk);
    checkOutput("fault_latched", {31'd0, fault}, {31'd0, SHTDN});
    applyStimulus(1'b0, 12'h400);
    @(negedge clk);
    checkOutput("fault_cleared", {31'd0, fault}, 0);
    checkOutput("en_off_pwm_h", {31'd0, pwm_h}, 0);
    checkOutput("en_off_pwm_l", {31'd0, pwm_l}, 0);
    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 12'h400);
    waitSynch(w); pushExp(992, 992, 1'b0, 1'b0);

    // mid-period reset at cnt==700
    waitSynch(w);
    repeat (699) @(negedge clk);
    checkOutput("pre_rst_pwm_h", {31'd0, pwm_h}, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_synch", {31'd0, pwm_synch}, 0);
    checkOutput("midrst_pwm_h", {31'd0, pwm_h}, 0);
    checkOutput("midrst_pwm_l", {31'd0, pwm_l}, 0);
    checkOutput("midrst_dir", {31'd0, dir}, 0);
    checkOutput("midrst_fault", {31'd0, fault}, 0);
    rst = 1'b0;
    waitSynch(w);
    checkOutput("midrst_synch_latency", w, 1);
    waitSynch(w); pushExp(992, 992, 1'b0, 1'b0);
    waitSynch(w);
    repeat (5) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    finishRun();
  end

endmodule
